// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one ALU between two requesters.
// Round-robin grant in IDLE, operands held on the ALU for a per-opcode
// latency in EXEC, then the captured result/flags are returned in RESP,
// tagged with the requester id. One operation in flight at a time.
module alu_issue_arbiter #(
    parameter int LAT_SIMPLE = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 20,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_opcode,
    input  logic [15:0] req0_src1,
    input  logic [15:0] req0_src2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_opcode,
    input  logic [15:0] req1_src1,
    input  logic [15:0] req1_src2,

    output logic        alu_valid,
    output logic [4:0]  alu_opcode,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_nzcv,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_nzcv,
    output logic        busy
);

    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b01001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        opc_q, opc_d;
    logic [15:0]       src1_q, src1_d;
    logic [15:0]       src2_q, src2_d;
    logic              id_q, id_d;
    logic              rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_nzcv_q, rsp_nzcv_d;

    logic              grant_id;
    logic              accept;
    logic [4:0]        win_opcode;
    logic [15:0]       win_src1;
    logic [15:0]       win_src2;
    logic [CNT_W-1:0]  win_lat;

    // Round-robin winner: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is gated by reset so every output reads 0 while rst is low.
    assign req0_ready = rst & (state_q == S_IDLE) & req0_valid & (grant_id == 1'b0);
    assign req1_ready = rst & (state_q == S_IDLE) & req1_valid & (grant_id == 1'b1);
    assign accept     = req0_ready | req1_ready;

    // Mux the winner's operation and pick its capture latency.
    always_comb begin
        win_opcode = grant_id ? req1_opcode : req0_opcode;
        win_src1   = grant_id ? req1_src1   : req0_src1;
        win_src2   = grant_id ? req1_src2   : req0_src2;
        unique case (win_opcode)
            OP_MUL:  win_lat = CNT_W'(LAT_MUL);
            OP_DIV:  win_lat = CNT_W'(LAT_DIV);
            default: win_lat = CNT_W'(LAT_SIMPLE);
        endcase
    end

    // Next-state and datapath update for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        opc_d        = opc_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_nzcv_d   = rsp_nzcv_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opc_d        = win_opcode;
                    src1_d       = win_src1;
                    src2_d       = win_src2;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = win_lat;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last EXEC cycle: the ALU's registered output now belongs to this op.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_nzcv_d   = alu_nzcv;
                    rsp_id_d     = id_q;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register is reset, including the latched operands, so outputs read 0 in reset.
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            opc_q        <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_nzcv_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            opc_q        <= opc_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_nzcv_q   <= rsp_nzcv_d;
        end
    end

    assign alu_valid  = (state_q == S_EXEC);
    assign alu_opcode = opc_q;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_nzcv   = rsp_nzcv_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Testbench for alu_issue_arbiter: a registered behavioural ALU, a
// transaction-level model of the arbiter checked every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_alu_issue_arbiter;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b01001;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_opcode;
    logic [15:0] req0_src1, req0_src2;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_opcode;
    logic [15:0] req1_src1, req1_src2;
    logic        alu_valid;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_src1, alu_src2;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_nzcv;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_result(alu_result), .alu_nzcv(alu_nzcv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_nzcv(rsp_nzcv), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: returns {nzcv, result}. 16-bit add/sub/and, 32-bit mul/div.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] r;
        logic [3:0]  f;
        r = '0; f = '0;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = {16'h0, w[15:0]};
                f = {w[15], w[15:0] == 16'h0, w[16], (a[15] == b[15]) && (w[15] != a[15])};
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = {16'h0, w[15:0]};
                f = {w[15], w[15:0] == 16'h0, a >= b, (a[15] != b[15]) && (w[15] != a[15])};
            end
            OP_AND: begin
                r = {16'h0, a & b};
                f = {r[15], r == 32'h0, 2'b00};
            end
            OP_MUL: begin
                r = 32'(a) * 32'(b);
                f = {r[31], r == 32'h0, 2'b00};
            end
            OP_DIV: begin
                r = (b == 16'h0) ? 32'h0 : 32'(a / b);
                f = {r[31], r == 32'h0, 2'b00};
            end
            default: begin r = '0; f = '0; end
        endcase
        return {f, r};
    endfunction

    // The ALU registers its result every cycle it sees input_valid.
    always @(posedge clk or negedge rst) begin
        if (!rst) {alu_nzcv, alu_result} <= '0;
        else if (alu_valid) {alu_nzcv, alu_result} <= alu_fn(alu_opcode, alu_src1, alu_src2);
    end

    // ---------------- transaction-level model ----------------
    int          m_cyc;
    logic        m_last, m_in_flight, m_resp;
    int          m_end;
    logic [4:0]  m_opc;
    logic [15:0] m_s1, m_s2;
    logic        m_id, m_rsp_id;
    logic [35:0] m_rsp;

    function automatic logic m_ready(input logic id);
        logic idle;
        idle = rst && !m_in_flight && !m_resp;
        if (id == 1'b0) return idle && req0_valid && (!req1_valid || m_last);
        else            return idle && req1_valid && (!req0_valid || !m_last);
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        return (op == OP_MUL) ? 3 : (op == OP_DIV) ? 20 : 2;
    endfunction

    // An accepted op occupies the ALU for its latency, then its response waits for rsp_ready.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc <= 0; m_last <= 1'b1; m_in_flight <= 1'b0; m_resp <= 1'b0; m_end <= 0;
            m_opc <= '0; m_s1 <= '0; m_s2 <= '0; m_id <= 1'b0; m_rsp_id <= 1'b0; m_rsp <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_resp) begin
                if (rsp_ready) m_resp <= 1'b0;
            end else if (m_in_flight) begin
                if (m_cyc == m_end) begin
                    m_rsp       <= alu_fn(m_opc, m_s1, m_s2);
                    m_rsp_id    <= m_id;
                    m_resp      <= 1'b1;
                    m_in_flight <= 1'b0;
                end
            end else if (m_ready(1'b0) || m_ready(1'b1)) begin
                m_id        <= m_ready(1'b1);
                m_last      <= m_ready(1'b1);
                m_opc       <= m_ready(1'b1) ? req1_opcode : req0_opcode;
                m_s1        <= m_ready(1'b1) ? req1_src1 : req0_src1;
                m_s2        <= m_ready(1'b1) ? req1_src2 : req0_src2;
                m_end       <= m_cyc + lat_of(m_ready(1'b1) ? req1_opcode : req0_opcode);
                m_in_flight <= 1'b1;
            end
        end
    end

    int av_cnt = 0;
    int rdy_busy_cnt = 0;

    // Per-cycle compare, sampled mid-low-phase after inputs have settled.
    always @(negedge clk) begin
        #2;
        check("req0_ready", req0_ready, m_ready(1'b0));
        check("req1_ready", req1_ready, m_ready(1'b1));
        check("alu_valid",  alu_valid,  m_in_flight);
        check("alu_opcode", alu_opcode, m_opc);
        check("alu_src1",   alu_src1,   m_s1);
        check("alu_src2",   alu_src2,   m_s2);
        check("rsp_valid",  rsp_valid,  m_resp);
        check("rsp_id",     rsp_id,     m_rsp_id);
        check("rsp_result", rsp_result, m_rsp[31:0]);
        check("rsp_nzcv",   rsp_nzcv,   m_rsp[35:32]);
        check("busy",       busy,       m_in_flight || m_resp);
        if (alu_valid) av_cnt++;
        if (busy && (req0_ready || req1_ready)) rdy_busy_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic do_req(input logic id, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic rdy;
        rdy = 1'b0;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_opcode = op; req0_src1 = a; req0_src2 = b; end
        else            begin req1_valid = 1'b1; req1_opcode = op; req1_src1 = a; req1_src2 = b; end
        for (int i = 0; i < 100; i++) begin
            #1;
            rdy = id ? req1_ready : req0_ready;
            if (rdy) break;
            step();
        end
        check("ready_timeout", rdy, 1'b1);
        step();
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic id, output logic [31:0] res, output logic [3:0] f);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            got = rsp_valid;
            if (got) break;
            step();
        end
        check("rsp_timeout", got, 1'b1);
        id = rsp_id; res = rsp_result; f = rsp_nzcv;
        step();
    endtask

    logic        g_id;
    logic [31:0] g_res;
    logic [3:0]  g_f;
    int          av0;
    logic [1:0]  rr_ids [4];
    logic [31:0] rr_res [4];
    int          rsp_seen;

    initial begin
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_src1 = 16'h7FFF; req0_src2 = 16'h0001;
        req1_valid = 1'b0; req1_opcode = '0; req1_src1 = '0; req1_src2 = '0;

        // Reset held 3 cycles with a pending request: nothing is accepted.
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check("rst_req0_ready", req0_ready, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        rst = 1'b1; #1;
        check("post_rst_req0_ready", req0_ready, 1'b1);

        // ADD 0x7FFF + 0x0001 from req0.
        av0 = av_cnt;
        do_req(1'b0, OP_ADD, 16'h7FFF, 16'h0001);
        get_rsp(g_id, g_res, g_f);
        check("add_id", g_id, 1'b0);
        check("add_result", g_res, 32'h0000_8000);
        check("add_nzcv", g_f, 4'b1001);
        check("add_alu_cycles", av_cnt - av0, 2);

        // MUL 0x0100 * 0x0100 from req1.
        av0 = av_cnt;
        do_req(1'b1, OP_MUL, 16'h0100, 16'h0100);
        get_rsp(g_id, g_res, g_f);
        check("mul_id", g_id, 1'b1);
        check("mul_result", g_res, 32'h0001_0000);
        check("mul_alu_cycles", av_cnt - av0, 3);

        // Round robin: last grant was req1, so the ties go 0,1,0,1.
        req0_valid = 1'b1; req0_opcode = OP_AND; req0_src1 = 16'hF0F0; req0_src2 = 16'h0FF0;
        req1_valid = 1'b1; req1_opcode = OP_AND; req1_src1 = 16'hAAAA; req1_src2 = 16'hFF00;
        for (int k = 0; k < 4; k++) begin
            get_rsp(g_id, g_res, g_f);
            rr_ids[k] = {1'b0, g_id};
            rr_res[k] = g_res;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_id%0d", k), rr_ids[k], (k % 2 == 0) ? 2'd0 : 2'd1);
            check($sformatf("rr_res%0d", k), rr_res[k], (k % 2 == 0) ? 32'h0000_00F0 : 32'h0000_AA00);
        end

        // DIV 100/7 from req0 with req1 waiting: no ready while busy.
        req1_valid = 1'b1; req1_opcode = OP_AND; req1_src1 = 16'h1; req1_src2 = 16'h1;
        av0 = av_cnt;
        rdy_busy_cnt = 0;
        do_req(1'b0, OP_DIV, 16'd100, 16'd7);
        get_rsp(g_id, g_res, g_f);
        req1_valid = 1'b0;
        check("div_id", g_id, 1'b0);
        check("div_result", g_res, 32'h0000_000E);
        check("div_alu_cycles", av_cnt - av0, 20);
        check("div_ready_while_busy", rdy_busy_cnt, 0);

        // Backpressure: SUB 5-9 from req1 held in RESP for 5 cycles, req0 waiting.
        rsp_ready = 1'b0;
        do_req(1'b1, OP_SUB, 16'd5, 16'd9);
        req0_valid = 1'b1; req0_opcode = OP_MUL; req0_src1 = 16'd3; req0_src2 = 16'd4;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rsp_valid) break;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_result", rsp_result, 32'h0000_FFFC);
            check("bp_rsp_nzcv", rsp_nzcv, 4'b1000);
            check("bp_rsp_id", rsp_id, 1'b1);
            check("bp_req0_ready", req0_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step(); #1;
        check("bp_after_rsp_valid", rsp_valid, 1'b0);
        check("bp_after_req0_ready", req0_ready, 1'b1);

        // Next op (MUL) is reset mid-EXEC: everything reads 0, no response follows.
        step(); step();
        check("pre_rst_alu_valid", alu_valid, 1'b1);
        rst = 1'b0; #1;
        check("mid_rst_alu_valid", alu_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_alu_src1", alu_src1, 16'h0);
        check("mid_rst_alu_opcode", alu_opcode, 5'h0);
        check("mid_rst_rsp_result", rsp_result, 32'h0);
        check("mid_rst_req0_ready", req0_ready, 1'b0);
        step(); step();
        req0_valid = 1'b0;
        rst = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid) rsp_seen++;
        end
        check("no_rsp_after_reset", rsp_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one ALU instance between two requesters (req0, req1).
- Grants round-robin and latches the winner's opcode and operands.
- Holds those operands on the ALU for a per-opcode latency (single-cycle logic/add, 3-stage multiply, multi-cycle divide), then captures result and NZCV into a response register and returns them tagged with the requester ID.
- Sits between the decode/issue stage and the ALU; one operation in flight at a time.

Parameters:
LAT_SIMPLE, 2, cycles from first alu_valid cycle to result capture for ADD/SUB/logic/unknown opcodes
LAT_MUL, 3, capture latency for MUL (5'b00011), matches src-register + product + output-register stages
LAT_DIV, 20, capture latency for DIV (5'b01001), covers worst-case divider iteration plus output register
CNT_W, 5, width of latency down-counter; must hold max(LAT_*)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_opcode  in  5  ALU opcode
req0_src1  in  16  operand 1
req0_src2  in  16  operand 2
req1_valid, req1_ready, req1_opcode, req1_src1, req1_src2: same as req0 for requester 1
alu_valid  out  1  drives ALU input_valid
alu_opcode  out  5  latched opcode to ALU
alu_src1  out  16  latched operand 1
alu_src2  out  16  latched operand 2
alu_result  in  32  ALU registered result
alu_nzcv  in  4  ALU registered flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that owns response (0/1)
rsp_result  out  32  captured result
rsp_nzcv  out  4  captured flags
busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=1 (req0 wins the first tie), all outputs 0, counter 0, latched operands 0. Reset mid-EXEC/RESP aborts the op; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE grant:
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant !last_grant.
  - reqX_ready = (state==IDLE) & grant==X (combinational). Never both high; both 0 outside IDLE.
- Accept (valid&ready at edge):
  - Latch opcode, src1, src2 and id.
  - last_grant <= id.
  - counter <= LAT_MUL if opcode==MUL, LAT_DIV if DIV, else LAT_SIMPLE.
  - Next state EXEC.
- EXEC:
  - alu_valid=1; alu_opcode/src1/src2 = latched values, held stable every cycle.
  - Counter decrements each cycle.
  - In the cycle counter==1: rsp_result<=alu_result, rsp_nzcv<=alu_nzcv, rsp_id<=latched id, next state RESP.
  - Outside EXEC, alu_valid=0 and alu_* keep their last latched values.
- RESP: rsp_valid=1, holding rsp_* stable until rsp_ready=1 at an edge, then IDLE. No new accept in the same cycle as the RESP->IDLE transition.
- Back-to-back throughput: latency+2 cycles per op minimum (1 accept, latency EXEC, ≥1 RESP).
- Unknown opcodes use LAT_SIMPLE; the response carries whatever the ALU returns (0/0000 for its default case).
- A requester deasserting valid while not granted is legal. A request must hold valid/opcode/src until ready.
- rsp_valid and reqX_ready are never high in the same cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req0_valid=1 -> all outputs 0, req0_ready=0; release -> req0_ready=1 next IDLE cycle.
- Single ADD: req0 ADD 0x7FFF+0x0001, rsp_ready=1 -> alu_valid high exactly 2 cycles; rsp_valid=1, rsp_id=0, rsp_result=0x00008000, rsp_nzcv=1001; back to IDLE.
- MUL latency: req1 MUL 0x0100*0x0100 -> alu_valid high 3 cycles with operands stable; rsp_result=0x00010000, rsp_id=1.
- DIV: req0 DIV 100/7 -> busy high 20 EXEC cycles, no ready on either port meanwhile; rsp_result=0x0000000E.
- Round-robin: req0 and req1 both continuously valid (AND ops) -> grants alternate 0,1,0,1 over 4 ops; req1 never starved.
- Backpressure plus mid-op reset: rsp_ready=0 for 5 cycles -> rsp_* held, no accept. Then assert rst=0 in EXEC of the next op -> outputs 0 immediately, no rsp_valid after release.
